// File: rtl/batalha_pkg.sv
// Shared constants for the game board: button indices, clock rate and
// auto-repeat defaults, plus the per-button repeat timer state encoding.
package batalha_pkg;

  localparam int N_BTN     = 5;
  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_FIRE  = 4;

  localparam int CLK_HZ = 25_000_000;

  // 500 ms before the first repeat, 150 ms between repeats
  localparam int REPEAT_DELAY_DEF  = CLK_HZ / 2;
  localparam int REPEAT_PERIOD_DEF = (CLK_HZ / 20) * 3;
  localparam int CNT_W_DEF         = 24;

  // Movement buttons repeat; FIRE only produces press events
  localparam logic [N_BTN-1:0] REPEAT_MASK_DEF = 5'b01111;

  typedef enum logic [1:0] {
    TMR_IDLE   = 2'd0,
    TMR_DELAY  = 2'd1,
    TMR_REPEAT = 2'd2
  } tmr_state_e;

endpackage

// File: rtl/button_event_arbiter_if.sv
// Event channel from the button arbiter to the cursor/fire logic.
// The master produces events; the slave accepts them with evt_ready.
interface button_event_arbiter_if #(
  parameter int ID_W = 3
);
  logic            evt_valid;
  logic            evt_ready;
  logic [ID_W-1:0] evt_id;
  logic            evt_repeat;
  logic            evt_overrun;

  modport master (
    output evt_valid,
    output evt_id,
    output evt_repeat,
    output evt_overrun,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_id,
    input  evt_repeat,
    input  evt_overrun,
    output evt_ready
  );
endinterface

// File: rtl/btn_repeat_timer.sv
// One button: rising-edge press detection and the hold-to-repeat timer.
// press and tick are single-cycle strobes decoded from registered state.
module btn_repeat_timer
  import batalha_pkg::*;
#(
  parameter int CNT_W         = 24,
  parameter int REPEAT_DELAY  = 12_500_000,
  parameter int REPEAT_PERIOD = 3_750_000,
  parameter bit REPEAT_EN     = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press,
  output logic tick
);

  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  tmr_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             btn_prev_q;

  // btn_prev resets high so a button held through reset must be released first
  assign press = btn & ~btn_prev_q;

  // A release in any state kills the tick for that cycle
  assign tick = btn & (((state_q == TMR_DELAY)  && (cnt_q == DELAY_LAST)) ||
                       ((state_q == TMR_REPEAT) && (cnt_q == PERIOD_LAST)));

  // Edge history plus IDLE -> DELAY -> REPEAT hold timer
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_prev_q <= 1'b1;
      state_q    <= TMR_IDLE;
      cnt_q      <= '0;
    end else begin
      btn_prev_q <= btn;
      if (!btn || !REPEAT_EN) begin
        state_q <= TMR_IDLE;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          TMR_IDLE: begin
            if (press) begin
              state_q <= TMR_DELAY;
              cnt_q   <= '0;
            end
          end
          TMR_DELAY: begin
            if (cnt_q == DELAY_LAST) begin
              state_q <= TMR_REPEAT;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          TMR_REPEAT: begin
            if (cnt_q == PERIOD_LAST) cnt_q <= '0;
            else                      cnt_q <= cnt_q + 1'b1;
          end
          default: begin
            state_q <= TMR_IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/button_event_arbiter.sv
// Collects press/repeat events from all buttons into a pending set and
// hands them out round-robin on one valid/ready channel.
module button_event_arbiter
  import batalha_pkg::*;
#(
  parameter int               N_BTN         = batalha_pkg::N_BTN,
  parameter int               CNT_W         = CNT_W_DEF,
  parameter int               REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int               REPEAT_PERIOD = REPEAT_PERIOD_DEF,
  parameter logic [N_BTN-1:0] REPEAT_MASK   = REPEAT_MASK_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_BTN-1:0]      btn_stable,
  button_event_arbiter_if.master evt
);

  localparam int ID_W = (N_BTN > 1) ? $clog2(N_BTN) : 1;

  logic [N_BTN-1:0] press, tick, set, busy, granted, pend_live, coalesce;
  logic [N_BTN-1:0] pend_q, pend_d, pend_rpt_q, pend_rpt_d;
  logic [ID_W-1:0]  rr_q, rr_d, id_q, id_d, grant_idx, cand;
  logic             valid_q, valid_d, rpt_q, rpt_d, overrun_q, overrun_d;
  logic             grant_found, load;

  genvar gi;
  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_btn
      btn_repeat_timer #(
        .CNT_W        (CNT_W),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD),
        .REPEAT_EN    (REPEAT_MASK[gi])
      ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn_stable[gi]),
        .press(press[gi]),
        .tick (tick[gi])
      );

      assign set[gi]       = press[gi] | tick[gi];
      // Event for this button sitting unaccepted in the output register
      assign busy[gi]      = valid_q && !evt.evt_ready && (id_q == ID_W'(gi));
      assign granted[gi]   = load && (grant_idx == ID_W'(gi));
      // Pending entry that survives this cycle's grant
      assign pend_live[gi] = pend_q[gi] && !granted[gi];
      assign coalesce[gi]  = set[gi] && (pend_live[gi] || busy[gi]);
    end
  endgenerate

  // Round-robin: first pending index after the last grant, wrapping
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = rr_q;
    cand        = rr_q;
    for (int k = 1; k <= N_BTN; k++) begin
      cand = ID_W'((int'(rr_q) + k) % N_BTN);
      if (!grant_found && pend_q[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign load = (!valid_q || evt.evt_ready) && grant_found;

  // Pending set update: a new event beats a same-cycle grant; repeats never mask a press
  always_comb begin
    pend_d     = pend_q;
    pend_rpt_d = pend_rpt_q;
    for (int i = 0; i < N_BTN; i++) begin
      if (set[i] && pend_live[i]) begin
        pend_d[i]     = 1'b1;
        pend_rpt_d[i] = pend_rpt_q[i] & ~press[i];
      end else if (set[i] && busy[i]) begin
        // Same event already on the bus and stalled: fold it in
        pend_d[i] = 1'b0;
      end else if (set[i]) begin
        pend_d[i]     = 1'b1;
        pend_rpt_d[i] = ~press[i];
      end else begin
        pend_d[i] = pend_live[i];
      end
    end
    overrun_d = |coalesce;
  end

  // Output register and round-robin pointer; fields only change on load
  always_comb begin
    valid_d = valid_q;
    id_d    = id_q;
    rpt_d   = rpt_q;
    rr_d    = rr_q;
    if (load) begin
      valid_d = 1'b1;
      id_d    = grant_idx;
      rpt_d   = pend_rpt_q[grant_idx];
      rr_d    = grant_idx;
    end else if (evt.evt_ready) begin
      valid_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q     <= '0;
      pend_rpt_q <= '0;
      valid_q    <= 1'b0;
      id_q       <= '0;
      rpt_q      <= 1'b0;
      overrun_q  <= 1'b0;
      rr_q       <= ID_W'(N_BTN - 1);
    end else begin
      pend_q     <= pend_d;
      pend_rpt_q <= pend_rpt_d;
      valid_q    <= valid_d;
      id_q       <= id_d;
      rpt_q      <= rpt_d;
      overrun_q  <= overrun_d;
      rr_q       <= rr_d;
    end
  end

  assign evt.evt_valid   = valid_q;
  assign evt.evt_id      = id_q;
  assign evt.evt_repeat  = rpt_q;
  assign evt.evt_overrun = overrun_q;

endmodule
